// File: rtl/tabuleiro_pkg.sv
// Shared constants, FSM encoding and helpers for the battleship shot resolver.
// Cell layout: bit SHIP marks a ship cell, bit HIT marks a cell already fired at.
package tabuleiro_pkg;

    localparam int BOARD_DIM_DEF = 8;
    localparam int MAX_PECAS_DEF = 11;

    localparam int SHIP = 1;
    localparam int HIT  = 0;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOOKUP = 2'd1,
        UPDATE = 2'd2
    } state_t;

    // True when both coordinates fall inside a dim x dim board (dim up to 16).
    function automatic logic coord_ok(input logic [3:0] x, input logic [3:0] y, input int dim);
        return ({1'b0, x} < 5'(dim)) && ({1'b0, y} < 5'(dim));
    endfunction

endpackage

// File: rtl/tabuleiro_mem.sv
// One player's board: BOARD_DIM x BOARD_DIM cells of {ship, hit}, with a
// combinational read port, a set-ship/set-hit write port and a synchronous wipe.
module tabuleiro_mem
    import tabuleiro_pkg::*;
#(
    parameter int BOARD_DIM = BOARD_DIM_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       clear,
    input  logic [3:0] rd_x,
    input  logic [3:0] rd_y,
    output logic [1:0] rd_cell,
    input  logic [3:0] wr_x,
    input  logic [3:0] wr_y,
    input  logic       set_ship,
    input  logic       set_hit
);

    localparam int CELLS = BOARD_DIM * BOARD_DIM;
    localparam int IDXW  = $clog2(CELLS);

    logic [IDXW-1:0] rd_idx;
    logic [IDXW-1:0] wr_idx;
    logic            wr_ok;
    logic [1:0]      cell_arr [CELLS];

    assign rd_idx = IDXW'(rd_y) * IDXW'(BOARD_DIM) + IDXW'(rd_x);
    assign wr_idx = IDXW'(wr_y) * IDXW'(BOARD_DIM) + IDXW'(wr_x);
    assign wr_ok  = coord_ok(wr_x, wr_y, BOARD_DIM);

    // Out-of-range reads alias other cells after truncation, so they read as empty.
    assign rd_cell = coord_ok(rd_x, rd_y, BOARD_DIM) ? cell_arr[rd_idx] : 2'b00;

    genvar gi;
    generate
        for (gi = 0; gi < CELLS; gi++) begin : g_cell
            logic [1:0] cell_reg;
            logic       sel;

            assign sel = wr_ok && (wr_idx == IDXW'(gi));

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    cell_reg <= 2'b00;
                end else if (clear) begin
                    cell_reg <= 2'b00;
                end else if (sel) begin
                    if (set_ship) cell_reg[SHIP] <= 1'b1;
                    if (set_hit)  cell_reg[HIT]  <= 1'b1;
                end
            end

            assign cell_arr[gi] = cell_reg;
        end
    endgenerate

endmodule

// File: rtl/tabuleiro_resolvedor.sv
// Holds both boards and piece counts; accepts ship placements and resolves
// shots with a fixed IDLE -> LOOKUP -> UPDATE sequence, answering hit/miss.
module tabuleiro_resolvedor
    import tabuleiro_pkg::*;
#(
    parameter int BOARD_DIM = BOARD_DIM_DEF,
    parameter int MAX_PECAS = MAX_PECAS_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       clear,
    input  logic       place_valid,
    input  logic       place_player,
    input  logic [3:0] place_x,
    input  logic [3:0] place_y,
    output logic       place_err,
    input  logic       tiro_valid,
    output logic       tiro_ready,
    input  logic       tiro_player,
    input  logic [3:0] coord_tiroX,
    input  logic [3:0] coord_tiroY,
    output logic       resp_valid,
    output logic       acertou_tiro,
    output logic       repetido,
    output logic       invalido,
    output logic [3:0] qtd_P1,
    output logic [3:0] qtd_P2,
    output logic       fim_jogo,
    output logic       vencedor
);

    state_t     state_reg;
    state_t     state_next;

    logic       shooter_reg;
    logic [3:0] x_reg;
    logic [3:0] y_reg;
    logic [1:0] tgt_reg;
    logic       in_range_reg;

    logic [3:0] qtd_p1_reg;
    logic [3:0] qtd_p2_reg;
    logic       fim_reg;
    logic       vencedor_reg;
    logic       acertou_reg;
    logic       repetido_reg;
    logic       invalido_reg;
    logic       resp_valid_reg;
    logic       place_err_reg;

    logic       ready;
    logic       shot_accept;
    logic [3:0] mem_rd_x;
    logic [3:0] mem_rd_y;
    logic [1:0] rd_cell_arr [2];
    logic [1:0] set_ship_vec;
    logic [1:0] set_hit_vec;

    logic [1:0] place_cell;
    logic [3:0] place_cnt;
    logic       place_req;
    logic       place_bad;
    logic       place_ok;
    logic       place_rej;

    logic       target;
    logic [1:0] tgt_cell;
    logic       hit_write;
    logic       is_hit;

    // ---------------- FSM ----------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        ready      = 1'b0;
        case (state_reg)
            IDLE: begin
                ready = ~fim_reg;
                if (tiro_valid && !fim_reg) state_next = LOOKUP;
            end
            LOOKUP:  state_next = UPDATE;
            UPDATE:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (clear) state_next = IDLE;
    end

    assign shot_accept = tiro_valid & ready;

    // ---------------- Board storage ----------------
    // In IDLE the shared read port serves placement checks; otherwise the latched shot.
    assign mem_rd_x = (state_reg == IDLE) ? place_x : x_reg;
    assign mem_rd_y = (state_reg == IDLE) ? place_y : y_reg;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_board
            assign set_ship_vec[gi] = place_ok  & (place_player == 1'(gi));
            assign set_hit_vec[gi]  = hit_write & (target == 1'(gi));

            tabuleiro_mem #(
                .BOARD_DIM (BOARD_DIM)
            ) u_mem (
                .clk      (clk),
                .reset    (reset),
                .clear    (clear),
                .rd_x     (mem_rd_x),
                .rd_y     (mem_rd_y),
                .rd_cell  (rd_cell_arr[gi]),
                .wr_x     (mem_rd_x),
                .wr_y     (mem_rd_y),
                .set_ship (set_ship_vec[gi]),
                .set_hit  (set_hit_vec[gi])
            );
        end
    endgenerate

    // ---------------- Placement ----------------
    assign place_cell = rd_cell_arr[place_player];
    assign place_cnt  = place_player ? qtd_p2_reg : qtd_p1_reg;
    // A simultaneous accepted shot silently swallows the placement.
    assign place_req  = place_valid & ~shot_accept;
    assign place_bad  = (state_reg != IDLE) | fim_reg
                      | ~coord_ok(place_x, place_y, BOARD_DIM)
                      | place_cell[SHIP]
                      | (place_cnt == 4'(MAX_PECAS));
    assign place_ok   = place_req & ~place_bad;
    assign place_rej  = place_req &  place_bad;

    // ---------------- Shot resolution ----------------
    // Player 0 fires at board 1 and vice versa.
    assign target    = ~shooter_reg;
    assign tgt_cell  = rd_cell_arr[target];
    assign hit_write = (state_reg == UPDATE) & in_range_reg & ~tgt_reg[HIT];
    assign is_hit    = hit_write & tgt_reg[SHIP];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shooter_reg    <= 1'b0;
            x_reg          <= 4'd0;
            y_reg          <= 4'd0;
            tgt_reg        <= 2'b00;
            in_range_reg   <= 1'b0;
            acertou_reg    <= 1'b0;
            repetido_reg   <= 1'b0;
            invalido_reg   <= 1'b0;
            resp_valid_reg <= 1'b0;
            place_err_reg  <= 1'b0;
        end else if (clear) begin
            shooter_reg    <= 1'b0;
            x_reg          <= 4'd0;
            y_reg          <= 4'd0;
            tgt_reg        <= 2'b00;
            in_range_reg   <= 1'b0;
            acertou_reg    <= 1'b0;
            repetido_reg   <= 1'b0;
            invalido_reg   <= 1'b0;
            resp_valid_reg <= 1'b0;
            place_err_reg  <= 1'b0;
        end else begin
            place_err_reg  <= place_rej;
            resp_valid_reg <= 1'b0;
            if (shot_accept) begin
                shooter_reg <= tiro_player;
                x_reg       <= coord_tiroX;
                y_reg       <= coord_tiroY;
            end
            if (state_reg == LOOKUP) begin
                tgt_reg      <= tgt_cell;
                in_range_reg <= coord_ok(x_reg, y_reg, BOARD_DIM);
            end
            if (state_reg == UPDATE) begin
                resp_valid_reg <= 1'b1;
                invalido_reg   <= ~in_range_reg;
                repetido_reg   <= in_range_reg & tgt_reg[HIT];
                acertou_reg    <= is_hit;
            end
        end
    end

    // Placement increments and hit decrements live in different FSM states.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            qtd_p1_reg   <= 4'd0;
            qtd_p2_reg   <= 4'd0;
            fim_reg      <= 1'b0;
            vencedor_reg <= 1'b0;
        end else if (clear) begin
            qtd_p1_reg   <= 4'd0;
            qtd_p2_reg   <= 4'd0;
            fim_reg      <= 1'b0;
            vencedor_reg <= 1'b0;
        end else begin
            if (place_ok) begin
                if (place_player) qtd_p2_reg <= qtd_p2_reg + 4'd1;
                else              qtd_p1_reg <= qtd_p1_reg + 4'd1;
            end
            if (is_hit) begin
                if (target) qtd_p2_reg <= qtd_p2_reg - 4'd1;
                else        qtd_p1_reg <= qtd_p1_reg - 4'd1;
                if ((target ? qtd_p2_reg : qtd_p1_reg) == 4'd1) begin
                    fim_reg      <= 1'b1;
                    vencedor_reg <= shooter_reg;
                end
            end
        end
    end

    assign tiro_ready   = ready;
    assign place_err    = place_err_reg;
    assign resp_valid   = resp_valid_reg;
    assign acertou_tiro = acertou_reg;
    assign repetido     = repetido_reg;
    assign invalido     = invalido_reg;
    assign qtd_P1       = qtd_p1_reg;
    assign qtd_P2       = qtd_p2_reg;
    assign fim_jogo     = fim_reg;
    assign vencedor     = vencedor_reg;

endmodule

// File: tb/tb_tabuleiro_resolvedor.sv
// Scoreboard bench for tabuleiro_resolvedor: directed scenarios then random
// placements/shots, checked against a board-level reference model.
module tb_tabuleiro_resolvedor;

    localparam int DIM  = 8;
    localparam int MAXP = 11;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       clear = 1'b0;
    logic       place_valid = 1'b0;
    logic       place_player = 1'b0;
    logic [3:0] place_x = 4'd0;
    logic [3:0] place_y = 4'd0;
    logic       place_err;
    logic       tiro_valid = 1'b0;
    logic       tiro_ready;
    logic       tiro_player = 1'b0;
    logic [3:0] coord_tiroX = 4'd0;
    logic [3:0] coord_tiroY = 4'd0;
    logic       resp_valid;
    logic       acertou_tiro;
    logic       repetido;
    logic       invalido;
    logic [3:0] qtd_P1;
    logic [3:0] qtd_P2;
    logic       fim_jogo;
    logic       vencedor;

    always #5 clk = ~clk;

    tabuleiro_resolvedor #(
        .BOARD_DIM (DIM),
        .MAX_PECAS (MAXP)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .clear        (clear),
        .place_valid  (place_valid),
        .place_player (place_player),
        .place_x      (place_x),
        .place_y      (place_y),
        .place_err    (place_err),
        .tiro_valid   (tiro_valid),
        .tiro_ready   (tiro_ready),
        .tiro_player  (tiro_player),
        .coord_tiroX  (coord_tiroX),
        .coord_tiroY  (coord_tiroY),
        .resp_valid   (resp_valid),
        .acertou_tiro (acertou_tiro),
        .repetido     (repetido),
        .invalido     (invalido),
        .qtd_P1       (qtd_P1),
        .qtd_P2       (qtd_P2),
        .fim_jogo     (fim_jogo),
        .vencedor     (vencedor)
    );

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int acertou;
        int repetido;
        int invalido;
        int q1;
        int q2;
        int fim;
        int venc;
        int cyc;
    } exp_t;

    exp_t sb[$];

    // Reference model: board contents as plain arrays, counts as integers.
    bit ship_m [2][DIM][DIM];
    bit hit_m  [2][DIM][DIM];
    int cnt_m  [2];
    bit fim_m;
    bit venc_m;

    task automatic chk(input string name, input int act, input int exp_v);
        n_vec++;
        if (act != exp_v) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp_v, cyc);
        end
    endtask

    function automatic void model_clear();
        foreach (ship_m[p, x, y]) begin
            ship_m[p][x][y] = 1'b0;
            hit_m[p][x][y]  = 1'b0;
        end
        cnt_m[0] = 0;
        cnt_m[1] = 0;
        fim_m    = 1'b0;
        venc_m   = 1'b0;
    endfunction

    // Monitor: every response pulse is matched against the oldest expectation.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (reset && resp_valid) begin
            if (sb.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL resp_unexpected: resp_valid=1, expected 0 (cycle %0d)", cyc);
            end else begin
                e = sb.pop_front();
                chk("latency", cyc - e.cyc, 2);
                chk("acertou_tiro", acertou_tiro, e.acertou);
                chk("repetido", repetido, e.repetido);
                chk("invalido", invalido, e.invalido);
                chk("qtd_P1", qtd_P1, e.q1);
                chk("qtd_P2", qtd_P2, e.q2);
                chk("fim_jogo", fim_jogo, e.fim);
                chk("vencedor", vencedor, e.venc);
                $display("shot resp: hit=%0b rep=%0b inv=%0b P1=%0d P2=%0d fim=%0b venc=%0b",
                         acertou_tiro, repetido, invalido, qtd_P1, qtd_P2, fim_jogo, vencedor);
            end
        end
    end

    task automatic place(input bit p, input int x, input int y);
        bit inr;
        bit e_err;
        inr   = (x < DIM) && (y < DIM);
        e_err = !inr || fim_m || (cnt_m[p] == MAXP);
        if (inr && ship_m[p][x][y]) e_err = 1'b1;
        place_valid  = 1'b1;
        place_player = p;
        place_x      = 4'(x);
        place_y      = 4'(y);
        @(negedge clk);
        place_valid = 1'b0;
        chk("place_err", place_err, e_err);
        if (!e_err) begin
            ship_m[p][x][y] = 1'b1;
            cnt_m[p]++;
        end
        chk("qtd_P1_place", qtd_P1, cnt_m[0]);
        chk("qtd_P2_place", qtd_P2, cnt_m[1]);
        $display("place P%0d (%0d,%0d): err=%0b P1=%0d P2=%0d", p + 1, x, y, place_err, qtd_P1, qtd_P2);
    endtask

    task automatic shoot(input bit p, input int x, input int y);
        exp_t e;
        int   t;
        t = p ? 0 : 1;
        chk("tiro_ready", tiro_ready, fim_m ? 0 : 1);
        if (fim_m) return;
        tiro_valid  = 1'b1;
        tiro_player = p;
        coord_tiroX = 4'(x);
        coord_tiroY = 4'(y);
        @(negedge clk);
        tiro_valid = 1'b0;
        e = '{default: 0};
        if (x >= DIM || y >= DIM) begin
            e.invalido = 1;
        end else if (hit_m[t][x][y]) begin
            e.repetido = 1;
        end else begin
            hit_m[t][x][y] = 1'b1;
            if (ship_m[t][x][y]) begin
                e.acertou = 1;
                cnt_m[t]--;
                if (cnt_m[t] == 0) begin
                    fim_m  = 1'b1;
                    venc_m = p;
                end
            end
        end
        e.q1  = cnt_m[0];
        e.q2  = cnt_m[1];
        e.fim = int'(fim_m);
        e.venc = int'(venc_m);
        e.cyc = cyc;
        sb.push_back(e);
        $display("shot P%0d at (%0d,%0d) accepted", p + 1, x, y);
        repeat (2) @(negedge clk);
    endtask

    task automatic do_clear();
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        model_clear();
        chk("qtd_P1_clear", qtd_P1, 0);
        chk("qtd_P2_clear", qtd_P2, 0);
        chk("ready_clear", tiro_ready, 1);
        $display("clear: P1=%0d P2=%0d ready=%0b", qtd_P1, qtd_P2, tiro_ready);
    endtask

    // Starts a shot and kills it in LOOKUP, by clear (use_reset=0) or async reset.
    task automatic abort_shot(input bit use_reset);
        tiro_valid  = 1'b1;
        tiro_player = 1'b0;
        coord_tiroX = 4'd2;
        coord_tiroY = 4'd1;
        @(negedge clk);
        tiro_valid = 1'b0;
        if (!use_reset) begin
            clear = 1'b1;
            @(negedge clk);
            clear = 1'b0;
        end else begin
            #2 reset = 1'b0;
            #1;
            chk("qtd_P2_async", qtd_P2, 0);
            chk("ready_async", tiro_ready, 1);
            #1 reset = 1'b1;
            @(negedge clk);
        end
        model_clear();
        chk("qtd_P1_abort", qtd_P1, 0);
        chk("qtd_P2_abort", qtd_P2, 0);
        chk("ready_abort", tiro_ready, 1);
        chk("resp_abort", resp_valid, 0);
        $display("abort (%s): P1=%0d P2=%0d ready=%0b", use_reset ? "reset" : "clear",
                 qtd_P1, qtd_P2, tiro_ready);
        repeat (4) @(negedge clk);
    endtask

    initial begin
        int r;
        model_clear();
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("rst_ready", tiro_ready, 1);
        chk("rst_place_err", place_err, 0);
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_flags", {acertou_tiro, repetido, invalido}, 0);
        chk("rst_qtd", {qtd_P1, qtd_P2}, 0);
        chk("rst_fim", {fim_jogo, vencedor}, 0);

        // Single ship, single winning shot.
        place(1'b1, 2, 1);
        shoot(1'b0, 2, 1);
        chk("ready_after_win", tiro_ready, 0);
        place(1'b0, 0, 0);
        shoot(1'b1, 0, 0);
        do_clear();

        // Full P2 fleet; hit then repeat.
        place(1'b1, 2, 1);
        for (int i = 0; i < 10; i++) place(1'b1, i % DIM, 3 + i / DIM);
        shoot(1'b0, 2, 1);
        shoot(1'b0, 2, 1);
        // Water on the empty P1 board, then repeat, then out of range.
        shoot(1'b1, 5, 5);
        shoot(1'b1, 5, 5);
        shoot(1'b0, 8, 0);
        shoot(1'b0, 0, 8);

        // Placement limits and duplicates on P1.
        for (int i = 0; i < 5; i++) place(1'b0, i % DIM, i / DIM);
        place(1'b0, 0, 0);
        for (int i = 5; i < 12; i++) place(1'b0, i % DIM, i / DIM);
        place(1'b0, 9, 2);

        // Aborts.
        do_clear();
        place(1'b1, 2, 1);
        abort_shot(1'b0);
        place(1'b1, 2, 1);
        abort_shot(1'b1);

        // Random play.
        for (int n = 0; n < 400; n++) begin
            r = $urandom_range(0, 99);
            if (r < 45) begin
                if ($urandom_range(0, 1) == 1)
                    place(1'($urandom_range(0, 1)), $urandom_range(0, 3), $urandom_range(0, 3));
                else
                    place(1'($urandom_range(0, 1)), $urandom_range(0, 8), $urandom_range(0, 8));
            end else if (r < 97) begin
                if ($urandom_range(0, 2) != 0)
                    shoot(1'($urandom_range(0, 1)), $urandom_range(0, 3), $urandom_range(0, 3));
                else
                    shoot(1'($urandom_range(0, 1)), $urandom_range(0, 8), $urandom_range(0, 8));
            end else begin
                do_clear();
            end
        end

        repeat (4) @(negedge clk);
        chk("sb_drained", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Watchdog so a stuck run still terminates with a report.
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, cycle %0d", cyc);
        $fatal(1, "timeout");
    end

endmodule
